// File: rtl/accum_job_arbiter_pkg.sv
// Shared definitions for the two-requester accumulate-job arbiter:
// default widths and the FSM state encoding.
package accum_job_arbiter_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_LEN_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_RESULT = 2'd2
   } state_e;

endpackage

// File: rtl/accum_job_arbiter_accum_unit.sv
// Running-sum register shared by all jobs: synchronous clear has priority
// over the enable-gated add; the sum wraps modulo 2^DATA_W.
module accum_unit
   import accum_job_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] add_i,
   output logic [DATA_W-1:0] sum_o
);

   logic [DATA_W-1:0] sum_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q <= '0;
      end else if (clr_i) begin
         sum_q <= '0;
      end else if (en_i) begin
         sum_q <= sum_q + add_i;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/accum_job_arbiter.sv
// Two requesters share one accumulator: a round-robin grant hands it to one
// job from command accept until its sum is taken from the result port.
module accum_job_arbiter
   import accum_job_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_cmd0_valid,
   output logic              io_cmd0_ready,
   input  logic [LEN_W-1:0]  io_cmd0_bits,
   input  logic              io_cmd1_valid,
   output logic              io_cmd1_ready,
   input  logic [LEN_W-1:0]  io_cmd1_bits,
   input  logic              io_data0_valid,
   output logic              io_data0_ready,
   input  logic [DATA_W-1:0] io_data0_bits,
   input  logic              io_data1_valid,
   output logic              io_data1_ready,
   input  logic [DATA_W-1:0] io_data1_bits,
   output logic              io_res_valid,
   input  logic              io_res_ready,
   output logic [DATA_W-1:0] io_res_bits,
   output logic              io_res_id,
   output logic              io_busy
);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;

   logic              grant0, grant1;
   logic [LEN_W-1:0]  cmd_len;
   logic              owner_valid;
   logic              cmd0_rdy, cmd1_rdy, data0_rdy, data1_rdy, res_vld;
   logic              acc_clr, acc_en;
   logic [DATA_W-1:0] acc_add, acc_sum;

   // On a tie the requester that was not served last wins.
   assign grant0      = io_cmd0_valid & (~io_cmd1_valid | last_q);
   assign grant1      = io_cmd1_valid & (~io_cmd0_valid | ~last_q);
   assign cmd_len     = grant1 ? io_cmd1_bits : io_cmd0_bits;
   assign owner_valid = owner_q ? io_data1_valid : io_data0_valid;
   assign acc_add     = owner_q ? io_data1_bits  : io_data0_bits;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cmd0_rdy  = 1'b0;
      cmd1_rdy  = 1'b0;
      data0_rdy = 1'b0;
      data1_rdy = 1'b0;
      res_vld   = 1'b0;
      acc_clr   = 1'b0;
      acc_en    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd0_rdy = grant0;
            cmd1_rdy = grant1;
            if (grant0 | grant1) begin
               cnt_d   = cmd_len;
               owner_d = grant1;
               acc_clr = 1'b1;
               state_d = (cmd_len == '0) ? ST_RESULT : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            data0_rdy = ~owner_q;
            data1_rdy = owner_q;
            if (owner_valid) begin
               acc_en = 1'b1;
               cnt_d  = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_d = ST_RESULT;
               end
            end
         end
         ST_RESULT: begin
            res_vld = 1'b1;
            if (io_res_ready) begin
               last_d  = owner_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   accum_unit #(.DATA_W(DATA_W)) u_accum (
      .clk   (clk),
      .reset (reset),
      .clr_i (acc_clr),
      .en_i  (acc_en),
      .add_i (acc_add),
      .sum_o (acc_sum)
   );

   // Handshake outputs are forced low while reset is held, even with valids high.
   assign io_cmd0_ready  = cmd0_rdy  & ~reset;
   assign io_cmd1_ready  = cmd1_rdy  & ~reset;
   assign io_data0_ready = data0_rdy & ~reset;
   assign io_data1_ready = data1_rdy & ~reset;
   assign io_res_valid   = res_vld   & ~reset;
   assign io_busy        = (state_q != ST_IDLE) & ~reset;
   assign io_res_bits    = acc_sum;
   assign io_res_id      = owner_q;

endmodule

// File: tb/tb_accum_job_arbiter.sv
// Bench for accum_job_arbiter: directed scenarios plus randomized jobs
// checked against a sum/round-robin reference model.
module tb_accum_job_arbiter;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 16;

   logic              clk   = 1'b0;
   logic              reset = 1'b1;
   logic              c0_v = 1'b0, c1_v = 1'b0;
   logic [LEN_W-1:0]  c0_b = '0, c1_b = '0;
   logic              d0_v = 1'b0, d1_v = 1'b0;
   logic [DATA_W-1:0] d0_b = '0, d1_b = '0;
   logic              r_rdy = 1'b0;
   logic              c0_r, c1_r, d0_r, d1_r, r_v, r_id, busy;
   logic [DATA_W-1:0] r_b;
   logic [5:0]        flags;

   int   n_cmp  = 0;
   int   n_mis  = 0;
   logic last_m = 1'b1;

   assign flags = {c0_r, c1_r, d0_r, d1_r, r_v, busy};

   always #5 clk = ~clk;

   accum_job_arbiter #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .io_cmd0_valid  (c0_v),
      .io_cmd0_ready  (c0_r),
      .io_cmd0_bits   (c0_b),
      .io_cmd1_valid  (c1_v),
      .io_cmd1_ready  (c1_r),
      .io_cmd1_bits   (c1_b),
      .io_data0_valid (d0_v),
      .io_data0_ready (d0_r),
      .io_data0_bits  (d0_b),
      .io_data1_valid (d1_v),
      .io_data1_ready (d1_r),
      .io_data1_bits  (d1_b),
      .io_res_valid   (r_v),
      .io_res_ready   (r_rdy),
      .io_res_bits    (r_b),
      .io_res_id      (r_id),
      .io_busy        (busy)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      c0_v = 1'b0; c1_v = 1'b0; d0_v = 1'b0; d1_v = 1'b0; r_rdy = 1'b0;
      c0_b = '0;   c1_b = '0;   d0_b = '0;   d1_b = '0;
   endtask

   task automatic test_reset();
      c0_v = 1'b1; c1_v = 1'b1; c0_b = 16'd3; c1_b = 16'd2;
      d0_v = 1'b1; d1_v = 1'b1; r_rdy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (flags !== 6'b000000) begin
            n_mis++; $display("FAIL reset_flags: got %b expected %b", flags, 6'b000000);
         end
         n_cmp++;
         if ({r_id, r_b} !== 33'd0) begin
            n_mis++; $display("FAIL reset_res: got id=%b bits=%h expected 0/0", r_id, r_b);
         end
      end
      next_cycle();
      reset = 1'b0;
      idle_inputs();
   endtask

   task automatic test_tie();
      logic              w;
      logic [DATA_W-1:0] x;
      for (int r = 0; r < 4; r++) begin
         w = (last_m == 1'b1) ? 1'b0 : 1'b1;
         x = $urandom;
         next_cycle();
         c0_v = 1'b1; c1_v = 1'b1; c0_b = 16'd1; c1_b = 16'd1;
         @(negedge clk);
         n_cmp++;
         if (flags !== (6'b100000 >> w)) begin
            n_mis++; $display("FAIL tie_grant round %0d: got %b expected %b", r, flags, 6'b100000 >> w);
         end
         next_cycle();
         c0_v = 1'b0; c1_v = 1'b0; d0_v = 1'b1; d1_v = 1'b1;
         d0_b = w ? $urandom : x;
         d1_b = w ? x : $urandom;
         @(negedge clk);
         n_cmp++;
         if (flags !== ((6'b001000 >> w) | 6'b000001)) begin
            n_mis++; $display("FAIL tie_data round %0d: got %b expected %b", r, flags, (6'b001000 >> w) | 6'b000001);
         end
         next_cycle();
         d0_v = 1'b0; d1_v = 1'b0; c0_v = 1'b1; c1_v = 1'b1; r_rdy = 1'b1;
         @(negedge clk);
         n_cmp++;
         if (flags !== 6'b000011) begin
            n_mis++; $display("FAIL tie_result_flags round %0d: got %b expected %b", r, flags, 6'b000011);
         end
         n_cmp++;
         if ({r_id, r_b} !== {w, x}) begin
            n_mis++; $display("FAIL tie_result round %0d: got id=%b bits=%h expected id=%b bits=%h", r, r_id, r_b, w, x);
         end
         last_m = w;
         next_cycle();
         idle_inputs();
      end
   endtask

   task automatic test_single_job();
      logic [DATA_W-1:0] vals [3];
      vals[0] = 32'd5; vals[1] = 32'd7; vals[2] = 32'hFFFF_FFFF;
      next_cycle();
      c0_v = 1'b1; c0_b = 16'd3;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b100000) begin
         n_mis++; $display("FAIL sj_grant: got %b expected %b", flags, 6'b100000);
      end
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         c0_v = 1'b0; d0_v = 1'b1; d0_b = vals[i];
         @(negedge clk);
         n_cmp++;
         if (flags !== 6'b001001) begin
            n_mis++; $display("FAIL sj_data %0d: got %b expected %b", i, flags, 6'b001001);
         end
      end
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         d0_v = 1'b0; r_rdy = (i == 1);
         @(negedge clk);
         n_cmp++;
         if (flags !== 6'b000011) begin
            n_mis++; $display("FAIL sj_res_flags %0d: got %b expected %b", i, flags, 6'b000011);
         end
         n_cmp++;
         if ({r_id, r_b} !== {1'b0, 32'h0000_000B}) begin
            n_mis++; $display("FAIL sj_res %0d: got id=%b bits=%h expected id=0 bits=0000000b", i, r_id, r_b);
         end
      end
      last_m = 1'b0;
      next_cycle();
      idle_inputs();
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b000000) begin
         n_mis++; $display("FAIL sj_idle: got %b expected %b", flags, 6'b000000);
      end
   endtask

   task automatic test_zero_len();
      next_cycle();
      c1_v = 1'b1; c1_b = 16'd0;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b010000) begin
         n_mis++; $display("FAIL zl_grant: got %b expected %b", flags, 6'b010000);
      end
      next_cycle();
      c1_v = 1'b0; d0_v = 1'b1; d1_v = 1'b1; d0_b = $urandom; d1_b = $urandom; r_rdy = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b000011) begin
         n_mis++; $display("FAIL zl_res_flags: got %b expected %b", flags, 6'b000011);
      end
      n_cmp++;
      if ({r_id, r_b} !== {1'b1, 32'd0}) begin
         n_mis++; $display("FAIL zl_res: got id=%b bits=%h expected id=1 bits=0", r_id, r_b);
      end
      last_m = 1'b1;
      next_cycle();
      r_rdy = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b000000) begin
         n_mis++; $display("FAIL zl_idle_data_ignored: got %b expected %b", flags, 6'b000000);
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] el [2];
      logic [DATA_W-1:0] exp_sum;
      int k;
      el[0] = $urandom; el[1] = $urandom;
      exp_sum = el[0] + el[1];
      k = 0;
      next_cycle();
      c0_v = 1'b1; c0_b = 16'd2;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b100000) begin
         n_mis++; $display("FAIL bp_grant: got %b expected %b", flags, 6'b100000);
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         c0_v = 1'b0; d0_v = (i % 2 == 1);
         d0_b = d0_v ? el[k] : $urandom;
         @(negedge clk);
         n_cmp++;
         if (flags !== 6'b001001) begin
            n_mis++; $display("FAIL bp_data %0d: got %b expected %b", i, flags, 6'b001001);
         end
         if (d0_v) k++;
      end
      for (int j = 0; j < 6; j++) begin
         next_cycle();
         d0_v = 1'b0; r_rdy = (j == 5);
         @(negedge clk);
         n_cmp++;
         if (flags !== 6'b000011 || {r_id, r_b} !== {1'b0, exp_sum}) begin
            n_mis++;
            $display("FAIL bp_hold %0d: got flags=%b id=%b bits=%h expected flags=000011 id=0 bits=%h", j, flags, r_id, r_b, exp_sum);
         end
      end
      last_m = 1'b0;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_nonowner_stall();
      logic [DATA_W-1:0] exp_sum;
      logic [DATA_W-1:0] e;
      exp_sum = '0;
      next_cycle();
      c0_v = 1'b1; c0_b = 16'd3; d1_v = 1'b1; d1_b = $urandom;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b100000) begin
         n_mis++; $display("FAIL ns_grant: got %b expected %b", flags, 6'b100000);
      end
      for (int i = 0; i < 3; i++) begin
         e = $urandom;
         exp_sum = exp_sum + e;
         next_cycle();
         c0_v = 1'b0; d0_v = 1'b1; d0_b = e; d1_b = $urandom;
         @(negedge clk);
         n_cmp++;
         if (flags !== 6'b001001) begin
            n_mis++; $display("FAIL ns_data %0d: got %b expected %b", i, flags, 6'b001001);
         end
      end
      next_cycle();
      d0_v = 1'b0; r_rdy = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b000011 || {r_id, r_b} !== {1'b0, exp_sum}) begin
         n_mis++;
         $display("FAIL ns_res: got flags=%b id=%b bits=%h expected flags=000011 id=0 bits=%h", flags, r_id, r_b, exp_sum);
      end
      last_m = 1'b0;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_reset_mid_job();
      next_cycle();
      c0_v = 1'b1; c0_b = 16'd4;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b100000) begin
         n_mis++; $display("FAIL rm_grant: got %b expected %b", flags, 6'b100000);
      end
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         c0_v = 1'b0; d0_v = 1'b1; d0_b = $urandom | 32'd1;
         @(negedge clk);
         n_cmp++;
         if (flags !== 6'b001001) begin
            n_mis++; $display("FAIL rm_data %0d: got %b expected %b", i, flags, 6'b001001);
         end
      end
      next_cycle();
      c1_v = 1'b1; c1_b = 16'd1; r_rdy = 1'b1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (flags !== 6'b000000 || {r_id, r_b} !== 33'd0) begin
         n_mis++; $display("FAIL rm_immediate: got flags=%b id=%b bits=%h expected all 0", flags, r_id, r_b);
      end
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b000000 || {r_id, r_b} !== 33'd0) begin
         n_mis++; $display("FAIL rm_held: got flags=%b id=%b bits=%h expected all 0", flags, r_id, r_b);
      end
      next_cycle();
      reset = 1'b0; d0_v = 1'b0;
      last_m = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b010000) begin
         n_mis++; $display("FAIL rm_regrant: got %b expected %b", flags, 6'b010000);
      end
      next_cycle();
      c1_v = 1'b0; d1_v = 1'b1; d1_b = 32'd9;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b000101) begin
         n_mis++; $display("FAIL rm_data1: got %b expected %b", flags, 6'b000101);
      end
      next_cycle();
      d1_v = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (flags !== 6'b000011 || {r_id, r_b} !== {1'b1, 32'd9}) begin
         n_mis++; $display("FAIL rm_res: got flags=%b id=%b bits=%h expected flags=000011 id=1 bits=9", flags, r_id, r_b);
      end
      last_m = 1'b1;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] q0[$], q1[$], exp_sum[$];
      logic              exp_id[$];
      for (int it = 0; it < 30; it++) begin
         int                mode, len0, len1, budget;
         logic              pend0, pend1, first, gid;
         logic [DATA_W-1:0] s0, s1, e;
         mode  = $urandom_range(0, 2);
         pend0 = (mode != 1);
         pend1 = (mode != 0);
         len0  = pend0 ? $urandom_range(0, 5) : 0;
         len1  = pend1 ? $urandom_range(0, 5) : 0;
         s0 = '0; s1 = '0;
         for (int i = 0; i < len0; i++) begin e = $urandom; q0.push_back(e); s0 = s0 + e; end
         for (int i = 0; i < len1; i++) begin e = $urandom; q1.push_back(e); s1 = s1 + e; end
         first = (pend0 && pend1) ? ~last_m : pend1;
         exp_id.push_back(first);
         exp_sum.push_back(first ? s1 : s0);
         if (pend0 && pend1) begin
            exp_id.push_back(~first);
            exp_sum.push_back(first ? s0 : s1);
         end
         budget = 0;
         while (exp_id.size() > 0 && budget < 200) begin
            next_cycle();
            budget++;
            c0_v = pend0; c0_b = LEN_W'(len0);
            c1_v = pend1; c1_b = LEN_W'(len1);
            d0_v = (q0.size() > 0) && ($urandom_range(0, 3) != 0);
            d0_b = d0_v ? q0[0] : $urandom;
            d1_v = (q1.size() > 0) && ($urandom_range(0, 3) != 0);
            d1_b = d1_v ? q1[0] : $urandom;
            r_rdy = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if ((c0_v && c0_r) || (c1_v && c1_r)) begin
               gid = c1_v && c1_r;
               n_cmp++;
               if ({c0_r, c1_r} === 2'b11 || gid !== exp_id[0]) begin
                  n_mis++; $display("FAIL rnd_grant it %0d: got ready=%b%b expected owner %b", it, c0_r, c1_r, exp_id[0]);
               end
               if (gid) pend1 = 1'b0; else pend0 = 1'b0;
            end
            if (d0_v && d0_r) void'(q0.pop_front());
            if (d1_v && d1_r) void'(q1.pop_front());
            if (r_v && r_rdy) begin
               n_cmp++;
               if ({r_id, r_b} !== {exp_id[0], exp_sum[0]}) begin
                  n_mis++; $display("FAIL rnd_result it %0d: got id=%b bits=%h expected id=%b bits=%h", it, r_id, r_b, exp_id[0], exp_sum[0]);
               end
               last_m = exp_id[0];
               void'(exp_id.pop_front());
               void'(exp_sum.pop_front());
            end
         end
         n_cmp++;
         if (exp_id.size() != 0) begin
            n_mis++; $display("FAIL rnd_timeout it %0d: got %0d results pending expected 0", it, exp_id.size());
         end
         exp_id.delete(); exp_sum.delete(); q0.delete(); q1.delete();
         next_cycle();
         idle_inputs();
      end
   endtask

   initial begin
      test_reset();
      test_tie();
      test_single_job();
      test_zero_len();
      test_backpressure();
      test_nonowner_stall();
      test_reset_mid_job();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/accum_job_arbiter.md
ACCUM_JOB_ARBITER -- requirements
Module: accum_job_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, element/sum width.
REQ-002 SHALL have parameter LEN_W, default 16, job length field width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports io_cmdN_valid  input  1 / io_cmdN_ready  output  1 / io_cmdN_bits  input  LEN_W, job command (element count) from requester N, N in {0,1}.
REQ-006 SHALL have ports io_dataN_valid  input  1 / io_dataN_ready  output  1 / io_dataN_bits  input  DATA_W, element stream from requester N, N in {0,1}.
REQ-007 SHALL have ports io_res_valid  output  1 / io_res_ready  input  1 / io_res_bits  output  DATA_W, job sum.
REQ-008 SHALL have port io_res_id  output  1  requester index owning current result.
REQ-009 SHALL have port io_busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCUM, RESULT; one job owns the shared accumulator from command accept to result accept.
REQ-011 SHALL, in IDLE, grant one requester with cmd_valid high; tie goes to the requester not granted last (round-robin).
REQ-012 SHALL assert io_cmdN_ready only in IDLE and only for the granted N; the other cmd_ready stays 0.
REQ-013 SHALL, on command handshake, load counter with cmd_bits, clear accumulator to 0, latch owner id.
REQ-014 SHALL go IDLE->ACCUM when cmd_bits != 0, IDLE->RESULT when cmd_bits == 0 (result 0).
REQ-015 SHALL, in ACCUM, assert io_dataN_ready only for the owner; non-owner data_ready stays 0 and its elements stall.
REQ-016 SHALL, on each owner data handshake, add data_bits to accumulator modulo 2^DATA_W (carry discarded) and decrement counter.
REQ-017 SHALL go ACCUM->RESULT on the handshake where counter == 1; earliest element accept is the cycle after command accept.
REQ-018 SHALL, in RESULT, hold io_res_valid=1 and io_res_bits/io_res_id stable until io_res_ready; on handshake go to IDLE and record owner as last-granted.
REQ-019 SHALL drive io_res_bits = accumulator; value after final element visible the cycle after that element's handshake.
REQ-020 SHALL not accept a new command in the RESULT-handshake cycle; earliest next command accept is the following cycle.
REQ-021 SHALL keep accumulator and counter unchanged on cycles with no owner data handshake (valid low = bubble).
REQ-022 SHALL ignore data_valid from either requester while in IDLE or RESULT.

Reset
REQ-023 SHALL, on reset assertion at any time (including mid-job), immediately enter IDLE, clear accumulator, counter and owner id to 0.
REQ-024 SHALL reset last-granted to 1 so requester 0 wins the first tie.
REQ-025 SHALL hold all ready outputs, io_res_valid, io_res_bits, io_res_id and io_busy at 0 during reset.
REQ-026 SHALL discard any in-flight job on reset; no partial result is emitted.

Structure
REQ-027 SHALL place the FSM state encoding and the DATA_W/LEN_W defaults in the shared package.
REQ-028 SHALL contain one sub-module, accum_unit: DATA_W register with synchronous clear and enable-gated add.
REQ-029 SHALL keep arbitration, counter and FSM in the top level; no other sub-modules.

Verification
REQ-030 Single job: cmd0=3, data0 = 5, 7, 0xFFFFFFFF back-to-back -> res_bits=0x0000000B, res_id=0, res_valid one cycle after third accept.
REQ-031 Tie: cmd0=1 and cmd1=1 both valid from reset -> requester 0 served first, then requester 1; repeat tie -> 0 again, strictly alternating.
REQ-032 Zero length: cmd1=0 -> no data_ready asserted, res_bits=0, res_id=1, valid the cycle after command accept.
REQ-033 Backpressure/bubbles: cmd0=2, data0 valid toggling, res_ready held low 5 cycles -> sum correct, res_bits stable, busy high throughout.
REQ-034 Non-owner stall: requester 1 drives data1_valid during requester 0 job -> data1_ready stays 0, requester 0 sum unaffected.
REQ-035 Reset mid-job: cmd0=4, reset after 2 elements -> outputs 0 immediately, no result; new cmd1=1 with 9 -> res_bits=9, res_id=1.
